// File: rtl/modulo5_serial_detector_if.sv
// Bundles the serial handshake and result signals of modulo5_serial_detector.
// master: the serializer/consumer side that drives bits and reads results.
// slave : the detector itself.
// Optional macro MOD5_PREFIX_OUT_EN adds the prefix_divisible signal.
interface modulo5_serial_detector_if #(
  parameter int FRAME_BITS = 8
);
  localparam int CNT_W = $clog2(FRAME_BITS);

  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             result_valid;
  logic [2:0]       result_remainder;
  logic             divisible;
  logic             frame_aborted;
  logic [CNT_W-1:0] bit_count;
`ifdef MOD5_PREFIX_OUT_EN
  logic             prefix_divisible;
`endif

  modport master (
    output serial_in, bit_valid, frame_start,
    input  result_valid, result_remainder, divisible, frame_aborted, bit_count
`ifdef MOD5_PREFIX_OUT_EN
    , input prefix_divisible
`endif
  );

  modport slave (
    input  serial_in, bit_valid, frame_start,
    output result_valid, result_remainder, divisible, frame_aborted, bit_count
`ifdef MOD5_PREFIX_OUT_EN
    , output prefix_divisible
`endif
  );
endinterface

// File: rtl/modulo5_serial_detector.sv
// Serial MSB-first modulo-5 detector. Tracks the running frame value mod 5
// with a five-state remainder FSM, counts accepted bits and, on the last bit
// of each frame, publishes the remainder and a divisible-by-5 flag together
// with a one-cycle result_valid pulse. frame_start discards a partial frame
// (pulsing frame_aborted when bits were lost).
// Optional macro MOD5_PREFIX_OUT_EN adds prefix_divisible, which reports after
// every accepted bit whether the bits received so far form a multiple of 5.
module modulo5_serial_detector #(
  parameter int FRAME_BITS = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  modulo5_serial_detector_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    R2 = 3'd2,
    R3 = 3'd3,
    R4 = 3'd4
  } rem_e;

  // Remainder update for one appended bit: (2*r + b) mod 5, as a lookup.
  function automatic rem_e mod5_step(input rem_e r, input logic b);
    case (r)
      R0:      return b ? R1 : R0;
      R1:      return b ? R3 : R2;
      R2:      return b ? R0 : R4;
      R3:      return b ? R2 : R1;
      R4:      return b ? R4 : R3;
      default: return R0;
    endcase
  endfunction

  rem_e             state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             result_valid_q;
  logic [2:0]       result_rem_q;
  logic             divisible_q;
  logic             aborted_q;
`ifdef MOD5_PREFIX_OUT_EN
  logic             prefix_q;
`endif

  rem_e             state_base;
  logic [CNT_W-1:0] cnt_base;
  rem_e             state_d;
  logic             last_bit;

  // Effective starting point for this cycle: frame_start or an illegal code
  // collapses the FSM to R0 before the incoming bit is applied.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_base = state_q;
    cnt_base   = cnt_q;
    if (bus.frame_start || !(state_q inside {R0, R1, R2, R3, R4})) begin
      state_base = R0;
    end
    if (bus.frame_start) begin
      cnt_base = '0;
    end
    state_d  = mod5_step(state_base, bus.serial_in);
    last_bit = (cnt_base == LAST_CNT);
  end

  // Remainder FSM, bit counter and registered result/abort outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q        <= R0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      result_rem_q   <= 3'd0;
      divisible_q    <= 1'b1;
      aborted_q      <= 1'b0;
`ifdef MOD5_PREFIX_OUT_EN
      prefix_q       <= 1'b0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      aborted_q      <= bus.frame_start && (cnt_q != '0);
      if (bus.bit_valid) begin
`ifdef MOD5_PREFIX_OUT_EN
        prefix_q <= (state_d == R0);
`endif
        if (last_bit) begin
          state_q        <= R0;
          cnt_q          <= '0;
          result_valid_q <= 1'b1;
          result_rem_q   <= state_d;
          divisible_q    <= (state_d == R0);
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_base + CNT_W'(1);
        end
      end else begin
        state_q <= state_base;
        cnt_q   <= cnt_base;
`ifdef MOD5_PREFIX_OUT_EN
        if (bus.frame_start) begin
          prefix_q <= 1'b0;
        end
`endif
      end
    end
  end

  assign bus.result_valid     = result_valid_q;
  assign bus.result_remainder = result_rem_q;
  assign bus.divisible        = divisible_q;
  assign bus.frame_aborted    = aborted_q;
  assign bus.bit_count        = cnt_q;
`ifdef MOD5_PREFIX_OUT_EN
  assign bus.prefix_divisible = prefix_q;
`endif

endmodule

// File: tb/tb_modulo5_serial_detector.sv
// Self-checking bench for modulo5_serial_detector: directed frames from the
// test plan followed by random bit/gap/frame_start traffic, all compared
// against an arithmetic reference model (accumulated value, % 5).
module tb_modulo5_serial_detector;
  localparam int FRAME_BITS = 8;
  localparam int CNT_W = $clog2(FRAME_BITS);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  modulo5_serial_detector_if #(.FRAME_BITS(FRAME_BITS)) bus();

  modulo5_serial_detector #(.FRAME_BITS(FRAME_BITS)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_q[$];

  // Reference model state
  int              m_cnt;
  longint unsigned m_val;
  int              m_rem;
  bit              m_div;
  bit              m_rv;
  bit              m_ab;
  bit              m_pre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_val = 0; m_rem = 0; m_div = 1'b1;
    m_rv = 1'b0; m_ab = 1'b0; m_pre = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit bv, input bit fs);
    m_rv = 1'b0;
    m_ab = 1'b0;
    if (fs) begin
      if (m_cnt != 0) m_ab = 1'b1;
      m_cnt = 0;
      m_val = 0;
      if (!bv) m_pre = 1'b0;
    end
    if (bv) begin
      m_val = m_val * 2 + longint'(b);
      m_cnt++;
      m_pre = (m_val % 5 == 0);
      if (m_cnt == FRAME_BITS) begin
        m_rem = int'(m_val % 5);
        m_div = (m_rem == 0);
        m_rv  = 1'b1;
        m_cnt = 0;
        m_val = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/result_valid"}, 32'(bus.result_valid), 32'(m_rv));
    check({tag, "/frame_aborted"}, 32'(bus.frame_aborted), 32'(m_ab));
    check({tag, "/remainder"}, 32'(bus.result_remainder), 32'(m_rem));
    check({tag, "/divisible"}, 32'(bus.divisible), 32'(m_div));
    check({tag, "/bit_count"}, 32'(bus.bit_count), 32'(m_cnt));
    check({tag, "/exclusive"}, 32'(bus.result_valid & bus.frame_aborted), 32'd0);
`ifdef MOD5_PREFIX_OUT_EN
    check({tag, "/prefix"}, 32'(bus.prefix_divisible), 32'(m_pre));
`endif
  endtask

  task automatic step(input bit b, input bit bv, input bit fs);
    @(negedge clock);
    bus.serial_in   = b;
    bus.bit_valid   = bv;
    bus.frame_start = fs;
    @(posedge clock);
    #1;
    cyc++;
    model_step(b, bv, fs);
    if (bus.result_valid === 1'b1) pulse_q.push_back(cyc);
    check_outputs($sformatf("c%0d", cyc));
  endtask

  task automatic send_frame(input logic [31:0] v, input int gap);
    for (int i = FRAME_BITS - 1; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0);
      if (i != 0) repeat (gap) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset_n         = 1'b0;
    bus.serial_in   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    repeat (cycles) begin
      @(posedge clock);
      #1;
      check_outputs("reset");
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ff;
    ff = 32'hFF;
    bus.serial_in   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    apply_reset(2);

    // Frame 25, continuous bits
    send_frame(32'd25, 0);
    check("f25_rem", 32'(bus.result_remainder), 32'd0);
    check("f25_div", 32'(bus.divisible), 32'd1);

    // Frame 13 with 2-cycle gaps
    send_frame(32'd13, 2);
    check("f13_rem", 32'(bus.result_remainder), 32'd3);
    check("f13_div", 32'(bus.divisible), 32'd0);

    // Back-to-back 10 then 11
    pulse_q.delete();
    send_frame(32'd10, 0);
    send_frame(32'd11, 0);
    check("b2b_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) check("b2b_spacing", 32'(pulse_q[1] - pulse_q[0]), 32'd8);
    check("f11_rem", 32'(bus.result_remainder), 32'd1);

    // 255 then 7
    send_frame(32'd255, 0);
    check("f255_rem", 32'(bus.result_remainder), 32'd0);
    send_frame(32'd7, 0);
    check("f7_rem", 32'(bus.result_remainder), 32'd2);
    check("f7_div", 32'(bus.divisible), 32'd0);

    // Abort: 3 bits of 0xFF, then frame_start with bit 0 of 4
    for (int i = 7; i >= 5; i--) step(ff[i], 1'b1, 1'b0);
    pulse_q.delete();
    step(1'b0, 1'b1, 1'b1);
    check("abort_pulse", 32'(bus.frame_aborted), 32'd1);
    check("abort_count", 32'(bus.bit_count), 32'd1);
    for (int i = 6; i >= 0; i--) step(i == 2 ? 1'b1 : 1'b0, 1'b1, 1'b0);
    check("abort_results", 32'(pulse_q.size()), 32'd1);
    check("f4_rem", 32'(bus.result_remainder), 32'd4);

    // Reset mid-frame after 5 bits, then frame 9
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    apply_reset(3);
    send_frame(32'd9, 0);
    check("f9_rem", 32'(bus.result_remainder), 32'd4);

    // Frame 5: prefix multiples of 5 after bits 0..4 and 7
    send_frame(32'd5, 0);
    check("f5_rem", 32'(bus.result_remainder), 32'd0);

    // frame_start alone with empty frame: no abort
    step(1'b0, 1'b0, 1'b1);
    check("idle_start_noabort", 32'(bus.frame_aborted), 32'd0);

    // Random traffic
    repeat (600) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
